// File: rtl/rect_loader.sv
// rect_loader
// ----------------------------------------------------------------------------
// Once per frame, copies the per-rectangle parameter block from data memory
// into the register arrays read by the collision and colour-selection stages.
// A start pulse in IDLE begins a linear burst of RECT_COUNT*5 reads, one per
// cycle. Rectangle i occupies BASE_ADDR+5i+{0..4} as {x, y, w, h, colour}.
// Read data returns one cycle after its address and is captured using
// counters delayed by one cycle.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   start       frame-start pulse, honoured only in IDLE
//   mem_rd_en   memory read strobe
//   mem_addr    word read address (wraps modulo 2^ADDR_WIDTH)
//   mem_data    read data, valid the cycle after mem_rd_en/mem_addr
//   rect_x/y/w/h, rect_colors  per-rectangle output arrays
//   busy        high from the first read cycle through the done cycle
//   done        one-cycle pulse when the new set is complete
//
// Build options
//   RECT_LOADER_DBUF_EN  when defined, captures land in shadow registers and
//                        all outputs update together at the end of the done
//                        cycle; otherwise entries update as words arrive.
//   DEFAULT_COLOR        default for the DEFAULT_COLOR parameter if defined.
// ----------------------------------------------------------------------------
`ifndef DEFAULT_COLOR
`define DEFAULT_COLOR 16'h0000
`endif

module rect_loader #(
    parameter int          RECT_COUNT    = 64,
    parameter int          ADDR_WIDTH    = 13,
    parameter int          BASE_ADDR     = 0,
    parameter logic [15:0] DEFAULT_COLOR = `DEFAULT_COLOR
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [15:0]           mem_data,
    output logic [15:0]           rect_x      [RECT_COUNT],
    output logic [15:0]           rect_y      [RECT_COUNT],
    output logic [15:0]           rect_w      [RECT_COUNT],
    output logic [15:0]           rect_h      [RECT_COUNT],
    output logic [15:0]           rect_colors [RECT_COUNT],
    output logic                  busy,
    output logic                  done
);

    localparam int N      = RECT_COUNT * 5;
    localparam int WORD_W = $clog2(N + 1);
    localparam int IDX_W  = (RECT_COUNT > 1) ? $clog2(RECT_COUNT) : 1;
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [WORD_W-1:0]     LAST_WORD = WORD_W'(N - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, COMMIT} state_t;

    state_t state_reg, state_next;

    logic [WORD_W-1:0] word_cnt_reg;
    logic [2:0]        field_cnt_reg;
    logic [IDX_W-1:0]  idx_cnt_reg;

    // Destination of the word currently on mem_data (issued last cycle).
    logic              cap_valid_reg;
    logic [2:0]        cap_field_reg;
    logic [IDX_W-1:0]  cap_idx_reg;

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        mem_rd_en  = 1'b0;
        mem_addr   = '0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = LOAD;
            end
            LOAD: begin
                mem_rd_en = 1'b1;
                mem_addr  = BASE + ADDR_WIDTH'(word_cnt_reg);
                busy      = 1'b1;
                if (word_cnt_reg == LAST_WORD) state_next = DRAIN;
            end
            DRAIN: begin
                // Final word is being captured; no read issued.
                busy       = 1'b1;
                state_next = COMMIT;
            end
            COMMIT: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || state_reg != LOAD) begin
            word_cnt_reg  <= '0;
            field_cnt_reg <= '0;
            idx_cnt_reg   <= '0;
        end else begin
            word_cnt_reg <= word_cnt_reg + 1'b1;
            if (field_cnt_reg == 3'd4) begin
                field_cnt_reg <= '0;
                idx_cnt_reg   <= idx_cnt_reg + 1'b1;
            end else begin
                field_cnt_reg <= field_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_valid_reg <= 1'b0;
            cap_field_reg <= '0;
            cap_idx_reg   <= '0;
        end else begin
            cap_valid_reg <= (state_reg == LOAD);
            cap_field_reg <= field_cnt_reg;
            cap_idx_reg   <= idx_cnt_reg;
        end
    end

    // One storage block per rectangle; field 4 is the colour.
    genvar gi;
    generate
        for (gi = 0; gi < RECT_COUNT; gi++) begin : g_rect
            logic [15:0] field_reg [5];
            logic        hit;

            assign hit = cap_valid_reg && (cap_idx_reg == IDX_W'(gi));

`ifdef RECT_LOADER_DBUF_EN
            logic [15:0] shadow_reg [5];

            always_ff @(posedge clk) begin
                for (int f = 0; f < 5; f++) begin
                    if (reset) begin
                        shadow_reg[f] <= (f == 4) ? DEFAULT_COLOR : 16'h0000;
                        field_reg[f]  <= (f == 4) ? DEFAULT_COLOR : 16'h0000;
                    end else begin
                        if (hit && cap_field_reg == 3'(f))
                            shadow_reg[f] <= mem_data;
                        // DRAIN precedes COMMIT, so the shadows are complete here.
                        if (state_reg == COMMIT)
                            field_reg[f] <= shadow_reg[f];
                    end
                end
            end
`else
            always_ff @(posedge clk) begin
                for (int f = 0; f < 5; f++) begin
                    if (reset)
                        field_reg[f] <= (f == 4) ? DEFAULT_COLOR : 16'h0000;
                    else if (hit && cap_field_reg == 3'(f))
                        field_reg[f] <= mem_data;
                end
            end
`endif

            assign rect_x[gi]      = field_reg[0];
            assign rect_y[gi]      = field_reg[1];
            assign rect_w[gi]      = field_reg[2];
            assign rect_h[gi]      = field_reg[3];
            assign rect_colors[gi] = field_reg[4];
        end
    endgenerate

endmodule
